// File: rtl/seg7_hex_capture_if.sv
// Signal bundle between a multiplexed 7-segment display tap and the hex capture block.
// The slave side is the capture block; the master side drives the display lines and consumes frames.
interface seg7_hex_capture_if;
  logic        seg_a;
  logic        seg_b;
  logic        seg_c;
  logic        seg_d;
  logic        seg_e;
  logic        seg_f;
  logic        seg_g;
  logic [3:0]  dig_sel;
  logic [3:0]  digit_valid;
  logic        frame_valid;
  logic        frame_ready;
  logic [15:0] frame_data;
  logic        pattern_err;
  logic        overrun;

  modport master (
    output seg_a, seg_b, seg_c, seg_d, seg_e, seg_f, seg_g,
    output dig_sel, frame_ready,
    input  digit_valid, frame_valid, frame_data, pattern_err, overrun
  );

  modport slave (
    input  seg_a, seg_b, seg_c, seg_d, seg_e, seg_f, seg_g,
    input  dig_sel, frame_ready,
    output digit_valid, frame_valid, frame_data, pattern_err, overrun
  );
endinterface

// File: rtl/seg7_hex_capture.sv
// Snoops a multiplexed hex 7-segment display, decodes each digit once it has been stable
// for STABLE_CYCLES samples, and hands complete 4-digit frames to a ready/valid consumer.
module seg7_hex_capture #(
  parameter int STABLE_CYCLES = 4
) (
  input logic                clk,
  input logic                rst,
  seg7_hex_capture_if.slave  bus
);

  logic [10:0]      samp_q;
  logic [10:0]      prev_q;
  logic [7:0]       stable_cnt;
  logic [3:0][3:0]  digits_q;
  logic [3:0]       digit_valid_q;
  logic [3:0]       digit_valid_next;
  logic             frame_valid_q;
  logic [15:0]      frame_data_q;
  logic             pattern_err_q;
  logic             overrun_q;

  logic             same;
  logic             capture;
  logic [3:0]       sel;
  logic [6:0]       seg;
  logic             sel_onehot;
  logic [1:0]       sel_idx;
  logic             glyph_hit;
  logic [3:0]       glyph_code;
  logic             frame_done;
  logic             load_digit;

  assign same       = (samp_q == prev_q);
  assign sel        = samp_q[10:7];
  assign seg        = samp_q[6:0];
  assign sel_onehot = (sel != 4'd0) && ((sel & (sel - 4'd1)) == 4'd0);
  assign frame_done = (digit_valid_q == 4'hF);

  // Counter reaching STABLE_CYCLES-1 on this edge marks the single capture point of the interval.
  assign capture    = same && (stable_cnt == 8'(STABLE_CYCLES - 2));
  assign load_digit = capture && sel_onehot && glyph_hit;

  always_comb begin
    sel_idx = 2'd0;
    case (sel)
      4'b0010: sel_idx = 2'd1;
      4'b0100: sel_idx = 2'd2;
      4'b1000: sel_idx = 2'd3;
      default: sel_idx = 2'd0;
    endcase
  end

  always_comb begin
    glyph_hit  = 1'b1;
    glyph_code = 4'h0;
    case (seg)
      7'b1111110: glyph_code = 4'h0;
      7'b0110000: glyph_code = 4'h1;
      7'b1101101: glyph_code = 4'h2;
      7'b1111001: glyph_code = 4'h3;
      7'b0110011: glyph_code = 4'h4;
      7'b1011011: glyph_code = 4'h5;
      7'b1011111: glyph_code = 4'h6;
      7'b1110000: glyph_code = 4'h7;
      7'b1111111: glyph_code = 4'h8;
      7'b1111011: glyph_code = 4'h9;
      7'b1110111: glyph_code = 4'hA;
      7'b0011111: glyph_code = 4'hB;
      7'b1001110: glyph_code = 4'hC;
      7'b0111101: glyph_code = 4'hD;
      7'b1001111: glyph_code = 4'hE;
      7'b1000111: glyph_code = 4'hF;
      default:    glyph_hit  = 1'b0;
    endcase
  end

  // Frame completion clears the valid set first so a same-cycle capture survives into the next frame.
  always_comb begin
    digit_valid_next = frame_done ? 4'd0 : digit_valid_q;
    if (load_digit) digit_valid_next[sel_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      samp_q        <= '0;
      prev_q        <= '0;
      stable_cnt    <= '0;
      digits_q      <= '0;
      digit_valid_q <= '0;
      frame_valid_q <= 1'b0;
      frame_data_q  <= '0;
      pattern_err_q <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      samp_q <= {bus.dig_sel, bus.seg_a, bus.seg_b, bus.seg_c, bus.seg_d,
                 bus.seg_e, bus.seg_f, bus.seg_g};
      prev_q <= samp_q;

      if (!same)
        stable_cnt <= '0;
      else if (stable_cnt != 8'(STABLE_CYCLES))
        stable_cnt <= stable_cnt + 8'd1;

      pattern_err_q <= capture && sel_onehot && !glyph_hit;
      if (load_digit) digits_q[sel_idx] <= glyph_code;
      digit_valid_q <= digit_valid_next;

      // An unaccepted frame is never overwritten; the newer one is dropped and flagged.
      if (frame_done) begin
        if (!frame_valid_q || bus.frame_ready) begin
          frame_data_q  <= digits_q;
          frame_valid_q <= 1'b1;
        end else begin
          overrun_q <= 1'b1;
        end
      end else if (frame_valid_q && bus.frame_ready) begin
        frame_valid_q <= 1'b0;
      end
    end
  end

  assign bus.digit_valid = digit_valid_q;
  assign bus.frame_valid = frame_valid_q;
  assign bus.frame_data  = frame_data_q;
  assign bus.pattern_err = pattern_err_q;
  assign bus.overrun     = overrun_q;

endmodule

// File: tb/tb_seg7_hex_capture.sv
// Bench for seg7_hex_capture: directed scenarios plus randomized display traffic
// compared cycle by cycle against a sample-history reference model.
module tb_seg7_hex_capture;

  localparam int STABLE = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;

  seg7_hex_capture_if bus ();

  seg7_hex_capture #(.STABLE_CYCLES(STABLE)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [6:0] glyph [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
  };

  // Reference model state: the history of sampled pairs decides when a digit is captured.
  logic [10:0] m_hist [$];
  logic [3:0]  m_dv;
  logic [3:0]  m_dig [4];
  logic        m_fv;
  logic [15:0] m_fd;
  logic        m_perr;
  logic        m_ovr;

  function automatic int streak_len();
    int n = 1;
    for (int i = m_hist.size() - 2; i >= 0; i--) begin
      if (m_hist[i] != m_hist[m_hist.size() - 1]) break;
      n++;
    end
    return n;
  endfunction

  task automatic model_step();
    logic [10:0] pair;
    logic [10:0] cap_pair;
    logic        cap;
    logic        found;
    logic [3:0]  code;
    int          idx;
    pair = {bus.dig_sel, bus.seg_a, bus.seg_b, bus.seg_c, bus.seg_d,
            bus.seg_e, bus.seg_f, bus.seg_g};
    if (rst) begin
      m_dv = 4'd0; m_fv = 1'b0; m_fd = 16'd0; m_perr = 1'b0; m_ovr = 1'b0;
      for (int i = 0; i < 4; i++) m_dig[i] = 4'd0;
      m_hist.delete();
      m_hist.push_back(11'd0);
      m_hist.push_back(11'd0);
      return;
    end
    cap      = (m_hist.size() > 0) && (streak_len() == STABLE);
    cap_pair = (m_hist.size() > 0) ? m_hist[m_hist.size() - 1] : 11'd0;
    m_perr   = 1'b0;
    if (m_dv == 4'hF) begin
      if (!m_fv || bus.frame_ready) begin
        m_fd = {m_dig[3], m_dig[2], m_dig[1], m_dig[0]};
        m_fv = 1'b1;
      end else begin
        m_ovr = 1'b1;
      end
      m_dv = 4'd0;
    end else if (m_fv && bus.frame_ready) begin
      m_fv = 1'b0;
    end
    if (cap && $countones(cap_pair[10:7]) == 1) begin
      idx = 0;
      for (int i = 0; i < 4; i++) if (cap_pair[7+i]) idx = i;
      found = 1'b0;
      code  = 4'd0;
      for (int g = 0; g < 16; g++)
        if (glyph[g] == cap_pair[6:0]) begin found = 1'b1; code = 4'(g); end
      if (found) begin
        m_dig[idx] = code;
        m_dv[idx]  = 1'b1;
      end else begin
        m_perr = 1'b1;
      end
    end
    m_hist.push_back(pair);
    while (m_hist.size() > STABLE + 2) void'(m_hist.pop_front());
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pair(input logic [3:0] sel, input logic [6:0] seg);
    bus.dig_sel = sel;
    {bus.seg_a, bus.seg_b, bus.seg_c, bus.seg_d, bus.seg_e, bus.seg_f, bus.seg_g} = seg;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic present_frame(input logic [15:0] value);
    for (int d = 0; d < 4; d++) begin
      set_pair(4'(1 << d), glyph[value[4*d +: 4]]);
      repeat (6) tick();
    end
  endtask

  task automatic test_reset();
    set_pair(4'b0001, glyph[3]);
    bus.frame_ready = 1'b1;
    do_reset();
    total += 5;
    if (bus.digit_valid !== 4'd0) begin bad++; $display("[TB] FAIL reset_dv got=%h exp=0", bus.digit_valid); end
    if (bus.frame_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_fv got=%b exp=0", bus.frame_valid); end
    if (bus.frame_data !== 16'd0) begin bad++; $display("[TB] FAIL reset_fd got=%h exp=0", bus.frame_data); end
    if (bus.pattern_err !== 1'b0) begin bad++; $display("[TB] FAIL reset_perr got=%b exp=0", bus.pattern_err); end
    if (bus.overrun !== 1'b0) begin bad++; $display("[TB] FAIL reset_ovr got=%b exp=0", bus.overrun); end
  endtask

  task automatic test_single_digit();
    int perr_seen = 0;
    logic [3:0] exp_dv;
    bus.frame_ready = 1'b1;
    set_pair(4'b0000, 7'd0);
    do_reset();
    set_pair(4'b0001, 7'b1111001);
    for (int t = 1; t <= 6; t++) begin
      tick();
      exp_dv = (t >= 5) ? 4'b0001 : 4'b0000;
      total++;
      if (bus.digit_valid !== exp_dv) begin
        bad++; $display("[TB] FAIL single_dv tick=%0d got=%h exp=%h", t, bus.digit_valid, exp_dv);
      end
      if (bus.pattern_err) perr_seen++;
    end
    total++;
    if (perr_seen != 0) begin bad++; $display("[TB] FAIL single_perr got=%0d exp=0", perr_seen); end
    for (int d = 1; d < 4; d++) begin
      set_pair(4'(1 << d), glyph[0]);
      repeat (6) tick();
    end
    total += 2;
    if (bus.frame_valid !== 1'b1) begin bad++; $display("[TB] FAIL single_frame_fv got=%b exp=1", bus.frame_valid); end
    if (bus.frame_data !== 16'h0003) begin bad++; $display("[TB] FAIL single_frame_fd got=%h exp=0003", bus.frame_data); end
  endtask

  task automatic test_frame();
    int fv_cycles = 0;
    logic [15:0] seen_fd = 16'd0;
    logic [6:0] segs [4] = '{7'b1011111, 7'b1110111, 7'b0011111, 7'b1000111};
    bus.frame_ready = 1'b1;
    set_pair(4'b0000, 7'd0);
    do_reset();
    for (int d = 0; d < 4; d++) begin
      set_pair(4'(1 << d), segs[d]);
      for (int t = 0; t < 6; t++) begin
        tick();
        if (bus.frame_valid) begin fv_cycles++; seen_fd = bus.frame_data; end
      end
    end
    set_pair(4'b0000, 7'd0);
    tick();
    if (bus.frame_valid) fv_cycles++;
    total += 4;
    if (fv_cycles != 1) begin bad++; $display("[TB] FAIL frame_fv_cycles got=%0d exp=1", fv_cycles); end
    if (seen_fd !== 16'hFBA6) begin bad++; $display("[TB] FAIL frame_data got=%h exp=FBA6", seen_fd); end
    if (bus.digit_valid !== 4'd0) begin bad++; $display("[TB] FAIL frame_dv_after got=%h exp=0", bus.digit_valid); end
    if (bus.frame_valid !== 1'b0) begin bad++; $display("[TB] FAIL frame_fv_after got=%b exp=0", bus.frame_valid); end
  endtask

  task automatic test_pattern_err();
    int perr_cnt = 0;
    int perr_tick = 0;
    bus.frame_ready = 1'b1;
    set_pair(4'b0000, 7'd0);
    do_reset();
    set_pair(4'b0100, 7'b1010101);
    for (int t = 1; t <= 6; t++) begin
      tick();
      if (bus.pattern_err) begin perr_cnt++; perr_tick = t; end
    end
    total += 3;
    if (perr_cnt != 1) begin bad++; $display("[TB] FAIL perr_count got=%0d exp=1", perr_cnt); end
    if (perr_tick != 5) begin bad++; $display("[TB] FAIL perr_tick got=%0d exp=5", perr_tick); end
    if (bus.digit_valid !== 4'd0) begin bad++; $display("[TB] FAIL perr_dv got=%h exp=0", bus.digit_valid); end
    perr_cnt = 0;
    set_pair(4'b0110, glyph[5]);
    for (int t = 0; t < 6; t++) begin tick(); if (bus.pattern_err) perr_cnt++; end
    set_pair(4'b0000, 7'b1010101);
    for (int t = 0; t < 6; t++) begin tick(); if (bus.pattern_err) perr_cnt++; end
    total += 2;
    if (perr_cnt != 0) begin bad++; $display("[TB] FAIL ghost_perr got=%0d exp=0", perr_cnt); end
    if (bus.digit_valid !== 4'd0) begin bad++; $display("[TB] FAIL ghost_dv got=%h exp=0", bus.digit_valid); end
  endtask

  task automatic test_toggle();
    int dv_nonzero = 0;
    bus.frame_ready = 1'b1;
    set_pair(4'b0000, 7'd0);
    do_reset();
    for (int p = 0; p < 10; p++) begin
      set_pair(4'b0001, (p % 2 == 0) ? glyph[1] : glyph[2]);
      for (int t = 0; t < 3; t++) begin
        tick();
        if (bus.digit_valid != 4'd0 || bus.pattern_err) dv_nonzero++;
      end
    end
    total++;
    if (dv_nonzero != 0) begin bad++; $display("[TB] FAIL toggle_capture got=%0d exp=0", dv_nonzero); end
  endtask

  task automatic test_overrun();
    bus.frame_ready = 1'b0;
    set_pair(4'b0000, 7'd0);
    do_reset();
    present_frame(16'h1234);
    present_frame(16'h5678);
    total += 4;
    if (bus.frame_data !== 16'h1234) begin bad++; $display("[TB] FAIL ovr_fd got=%h exp=1234", bus.frame_data); end
    if (bus.frame_valid !== 1'b1) begin bad++; $display("[TB] FAIL ovr_fv got=%b exp=1", bus.frame_valid); end
    if (bus.overrun !== 1'b1) begin bad++; $display("[TB] FAIL ovr_flag got=%b exp=1", bus.overrun); end
    if (bus.digit_valid !== 4'd0) begin bad++; $display("[TB] FAIL ovr_dv got=%h exp=0", bus.digit_valid); end
    bus.frame_ready = 1'b1;
    set_pair(4'b0000, 7'd0);
    tick();
    total += 2;
    if (bus.frame_valid !== 1'b0) begin bad++; $display("[TB] FAIL ovr_accept_fv got=%b exp=0", bus.frame_valid); end
    if (bus.overrun !== 1'b1) begin bad++; $display("[TB] FAIL ovr_sticky got=%b exp=1", bus.overrun); end
  endtask

  task automatic test_reset_mid();
    logic [3:0] exp_dv;
    bus.frame_ready = 1'b0;
    set_pair(4'b0000, 7'd0);
    do_reset();
    present_frame(16'h1234);
    set_pair(4'b0001, glyph[9]);
    repeat (2) tick();
    rst = 1'b1;
    tick();
    total += 5;
    if (bus.digit_valid !== 4'd0) begin bad++; $display("[TB] FAIL mid_dv got=%h exp=0", bus.digit_valid); end
    if (bus.frame_valid !== 1'b0) begin bad++; $display("[TB] FAIL mid_fv got=%b exp=0", bus.frame_valid); end
    if (bus.frame_data !== 16'd0) begin bad++; $display("[TB] FAIL mid_fd got=%h exp=0", bus.frame_data); end
    if (bus.pattern_err !== 1'b0) begin bad++; $display("[TB] FAIL mid_perr got=%b exp=0", bus.pattern_err); end
    if (bus.overrun !== 1'b0) begin bad++; $display("[TB] FAIL mid_ovr got=%b exp=0", bus.overrun); end
    rst = 1'b0;
    for (int t = 1; t <= 5; t++) begin
      tick();
      exp_dv = (t >= 5) ? 4'b0001 : 4'b0000;
      total++;
      if (bus.digit_valid !== exp_dv) begin
        bad++; $display("[TB] FAIL mid_recapture tick=%0d got=%h exp=%h", t, bus.digit_valid, exp_dv);
      end
    end
  endtask

  task automatic test_random();
    logic [3:0] sel;
    logic [6:0] seg;
    int kind;
    int hold;
    bus.frame_ready = 1'b0;
    set_pair(4'b0000, 7'd0);
    do_reset();
    for (int n = 0; n < 200; n++) begin
      kind = $urandom_range(0, 9);
      if (kind < 6)      sel = 4'(1 << $urandom_range(0, 3));
      else if (kind < 8) sel = 4'd0;
      else               sel = 4'($urandom_range(0, 15));
      seg  = ($urandom_range(0, 3) != 0) ? glyph[$urandom_range(0, 15)] : 7'($urandom_range(0, 127));
      hold = $urandom_range(1, 8);
      set_pair(sel, seg);
      for (int t = 0; t < hold; t++) begin
        bus.frame_ready = ($urandom_range(0, 2) != 0);
        rst = ($urandom_range(0, 299) == 0);
        tick();
        total += 5;
        if (bus.digit_valid !== m_dv) begin bad++; $display("[TB] FAIL rand_dv n=%0d got=%h exp=%h", n, bus.digit_valid, m_dv); end
        if (bus.frame_valid !== m_fv) begin bad++; $display("[TB] FAIL rand_fv n=%0d got=%b exp=%b", n, bus.frame_valid, m_fv); end
        if (bus.frame_data !== m_fd) begin bad++; $display("[TB] FAIL rand_fd n=%0d got=%h exp=%h", n, bus.frame_data, m_fd); end
        if (bus.pattern_err !== m_perr) begin bad++; $display("[TB] FAIL rand_perr n=%0d got=%b exp=%b", n, bus.pattern_err, m_perr); end
        if (bus.overrun !== m_ovr) begin bad++; $display("[TB] FAIL rand_ovr n=%0d got=%b exp=%b", n, bus.overrun, m_ovr); end
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    bus.frame_ready = 1'b0;
    set_pair(4'b0000, 7'd0);
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    test_reset();
    test_single_digit();
    test_frame();
    test_pattern_err();
    test_toggle();
    test_overrun();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seg7_hex_capture.md
SEG7_HEX_CAPTURE -- requirements
Module: seg7_hex_capture

Interface
REQ-001 Parameter: STABLE_CYCLES, default 4, number of consecutive identical samples (range 2..255) required before a digit is captured.
REQ-002 clk  input  1  single system clock; all logic on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 seg_a..seg_g  input  1 each  active-high segment lines of a multiplexed hex 7-segment display.
REQ-005 dig_sel  input  4  active-high digit enable; bit i selects digit i; one-hot expected.
REQ-006 digit_valid  output  4  bit i set when working digit i holds a captured value for the current frame.
REQ-007 frame_valid  output  1  completed 4-digit frame available on frame_data.
REQ-008 frame_ready  input  1  consumer accepts frame_data when high together with frame_valid.
REQ-009 frame_data  output  16  captured frame; digit i in bits [4i+3:4i].
REQ-010 pattern_err  output  1  one-cycle pulse: a stable, one-hot-selected pattern matched no hex glyph.
REQ-011 overrun  output  1  sticky: a new frame completed while the previous frame was still unaccepted.

Function
REQ-012 Glyph table {a,b,c,d,e,f,g}: 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011, A=1110111, b=0011111, C=1001110, d=0111101, E=1001111, F=1000111.
REQ-013 The 11-bit pair {dig_sel, seg} is registered once per cycle (sample stage); all decisions use registered values.
REQ-014 A stability counter counts consecutive cycles in which the sampled pair equals the previous sample, clears to 0 on any difference, and saturates at STABLE_CYCLES.
REQ-015 Capture fires exactly once per stable interval: on the cycle the counter first reaches STABLE_CYCLES-1; no further capture until the pair changes and restabilises.
REQ-016 Capture latency: a pair presented before rising edge E and held constant updates the digit slot at edge E+STABLE_CYCLES (5th edge for the default).
REQ-017 On capture with one-hot dig_sel and a table match: working digit i is loaded with the 4-bit code and digit_valid[i] is set; a recapture of an already-valid digit overwrites its value.
REQ-018 On capture with one-hot dig_sel and no table match: pattern_err pulses high for one cycle; the working digit and digit_valid are unchanged.
REQ-019 dig_sel equal to 0000 or with more than one bit set: no capture, no pattern_err (blanking/ghosting interval).
REQ-020 Frame completion: on the edge after digit_valid becomes 1111, the working digits are copied to frame_data, frame_valid is set, and digit_valid clears to 0000.
REQ-021 A capture in the completion cycle is applied after the clear (its digit_valid bit stays set for the next frame).
REQ-022 frame_valid and frame_data hold stable until the cycle where frame_valid and frame_ready are both high; frame_valid drops on the following edge unless a new frame completes in that same cycle, in which case frame_data reloads and frame_valid stays high.
REQ-023 A frame completing while frame_valid is high and frame_ready is low: frame_data is not modified, overrun is set, digit_valid still clears (completed frame discarded).
REQ-024 frame_ready while frame_valid is low has no effect.

Reset
REQ-025 rst high at an edge: digit_valid=0000, frame_valid=0, frame_data=0x0000, pattern_err=0, overrun=0, stability counter=0, sample register=0, working digits=0.
REQ-026 Reset overrides any in-progress stable interval, pending frame, or handshake; the first capture after reset requires a full STABLE_CYCLES interval after rst is deasserted.

Verification
REQ-027 Hold dig_sel=0001, seg=1111001 for 6 cycles -> digit 0 = 0x3, digit_valid=0001 at the 5th edge, exactly one capture.
REQ-028 Present digits 0..3 = 1011111, 1110111, 0011111, 1000111, each for 6 cycles, with frame_ready=1 -> frame_data=0xFBA6, frame_valid high one cycle, digit_valid=0000 after.
REQ-029 dig_sel=0100, seg=1010101 held 6 cycles -> single pattern_err pulse; digit_valid unchanged; dig_sel=0110 or 0000 held 6 cycles -> no capture, no pattern_err.
REQ-030 Toggle seg every 3 cycles with STABLE_CYCLES=4 -> no capture ever; digit_valid remains 0000.
REQ-031 frame_ready=0, complete two frames (0x1234 then 0x5678) -> frame_data stays 0x1234, overrun=1; then frame_ready=1 -> frame_valid drops next edge, overrun stays 1.
REQ-032 Assert rst mid-capture with frame_valid=1 -> all outputs at REQ-025 values next edge; subsequent digit captured only after a full fresh interval.
